conv3x3_stream: RTL
===================

Name: conv3x3_stream

Overview:
- Streaming 3x3 2-D convolution with zero ("same") padding over a 32x32 raster of signed 8-bit pixels.
- Produces a 32x32 raster of signed 22-bit results, one per output position.
- Sits directly upstream of the 2x2 max-pooling stage. Its result_out/result_valid/done_signal feed that stage's pixel_in/pixel_valid and frame bookkeeping.
- Kernel weights and bias are latched per frame on start_signal.

Parameters:
- IMG_WIDTH, 32, pixels per input/output row.
- IMG_HEIGHT, 32, rows per frame.
- DATA_W, 8, signed input pixel and weight width.
- OUT_W, 22, signed result width.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- start_signal  input  1  one-cycle frame start; latches weights and bias, clears counters.
- weight_in  input  9*DATA_W  nine signed weights, w[k] = bits [8k+7:8k], k = 3*row+col, row 0 = top.
- bias_in  input  16  signed bias added to every result.
- pixel_valid  input  1  pixel_in is valid this cycle.
- pixel_in  input  DATA_W  signed input pixel, raster order.
- in_ready  output  1  pixel is accepted when pixel_valid && in_ready.
- result_out  output  OUT_W  signed convolution result, raster order.
- result_valid  output  1  one-cycle strobe per result.
- done_signal  output  1  one-cycle pulse after the last result of a frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; all counters, line buffers, window registers, weights and bias cleared.
  - in_ready=0, result_valid=0, result_out=0, done_signal=0.
- States: IDLE, RUN, PAD, FLUSH, DONE.
  - IDLE: in_ready=0. start_signal -> RUN.
  - RUN: in_ready=1. The accepted pixel at column IMG_WIDTH-1 -> PAD.
  - PAD: one cycle, in_ready=0, injects a zero pad column. Next state is RUN, or FLUSH if the last row was just completed.
  - FLUSH: in_ready=0, injects IMG_WIDTH+1 zero pixels (virtual pad row) -> DONE.
  - DONE: done_signal asserts once the final result has emitted -> IDLE.
- start_signal in any state aborts the current frame, relatches weights/bias, clears positions and pipeline valids, and enters RUN the next cycle. Results in flight are discarded.
- Virtual grid:
  - Positions are (vr,vc), vr in 0..IMG_HEIGHT, vc in 0..IMG_WIDTH.
  - Real pixels occupy vr<IMG_HEIGHT, vc<IMG_WIDTH; pad positions carry 0.
  - Two line buffers of IMG_WIDTH+1 entries plus a 3x3 window shift register.
  - Window rows/columns falling before row 0 or column 0 read as 0.
- Result rule:
  - Processing virtual position (vr,vc) with vr>=1 and vc>=1 produces the result for output (vr-1, vc-1).
  - That result's window is centred on input (vr-1, vc-1), with out-of-frame taps = 0.
  - Result = sum over k of w[k]*x[k], plus bias.
- Arithmetic:
  - Products are 16-bit signed.
  - The 9-term sum plus bias is carried at 20 bits signed (cannot overflow) and sign-extended to OUT_W.
  - No saturation or rounding.
- Latency:
  - Stage 1 registers the nine products.
  - Stage 2 registers the sum and asserts result_valid.
  - result_valid therefore rises 2 cycles after the position is processed, i.e. after the pixel is accepted or the pad is injected.
- Gaps in pixel_valid stall RUN without penalty. Output is never back-pressured.
- Per frame: exactly IMG_WIDTH*IMG_HEIGHT results.
  - done_signal pulses one cycle after the last result_valid.
  - pixel_valid during PAD/FLUSH/IDLE/DONE is ignored; the pixel is not accepted.
- Reset asserted mid-frame: immediate clear to the reset values above. No result or done is emitted afterwards.

Test Plan:
- Identity kernel (w[4]=1, others 0, bias 0), input x(r,c)=(32r+c) mod 128, no gaps -> 1024 results equal to the inputs in raster order; done_signal one cycle after result 1023.
- All-ones kernel, all-ones input, bias 0 -> corners 4, non-corner edges 6, interior 9; total 1024 results.
- All weights -128, all inputs -128, bias 32767 -> interior result 180223, corner (0,0) 98303, no wrap.
- Random pixel_valid gaps (~40% duty) -> results identical to the gap-free run; in_ready low for exactly 1 cycle after each 32nd accepted pixel and 33 cycles after the 1024th; pixels offered while in_ready=0 are not consumed.
- start_signal after 500 accepted pixels, then a full new frame with different weights -> no results from the aborted frame after the restart plus pipeline drain; new frame yields 1024 correct results and one done_signal.
- rst pulsed low mid-frame (asynchronous, between clock edges) -> all outputs 0 immediately; no done_signal; a subsequent start_signal yields a correct frame.

Source files
------------

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 zero-padded convolution over a fixed raster
// Walks a (H+1)x(W+1) virtual grid so the trailing pad column/row flush the window.
module conv3x3_stream #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_signal,
  input  logic [9*DATA_W-1:0] weight_in,
  input  logic [15:0]         bias_in,
  input  logic                pixel_valid,
  input  logic [DATA_W-1:0]   pixel_in,
  output logic                in_ready,
  output logic [OUT_W-1:0]    result_out,
  output logic                result_valid,
  output logic                done_signal
);

  localparam int LB_N = IMG_WIDTH + 1;
  localparam int CW   = $clog2(IMG_WIDTH + 2);
  localparam int RW   = $clog2(IMG_HEIGHT + 2);
  localparam int PW   = 2 * DATA_W;
  localparam int SW   = PW + 4;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAD, S_FLUSH, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [RW-1:0]              vr_q, vr_d;
  logic [CW-1:0]              vc_q, vc_d;
  logic [9*DATA_W-1:0]        w_q, w_d;
  logic [15:0]                bias_q, bias_d;
  logic [LB_N*DATA_W-1:0]     lb1_q, lb1_d;
  logic [LB_N*DATA_W-1:0]     lb2_q, lb2_d;
  logic [DATA_W-1:0]          win_q [9];
  logic [DATA_W-1:0]          win_d [9];
  logic                       wvalid_q, wvalid_d;
  logic signed [PW-1:0]       prod_q [9];
  logic signed [PW-1:0]       prod_d [9];
  logic                       pvalid_q, pvalid_d;
  logic [OUT_W-1:0]           res_q, res_d;
  logic                       res_valid_q, res_valid_d;
  logic                       done_q, done_d;

  logic                       adv;
  logic [DATA_W-1:0]          pix;
  logic [DATA_W-1:0]          lb1_top, lb2_top;
  logic signed [SW-1:0]       acc;

  function automatic logic signed [PW-1:0] sx(input logic [DATA_W-1:0] v);
    return {{(PW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Oldest line-buffer entry is the same column one (or two) virtual rows back.
  assign lb1_top = lb1_q[LB_N*DATA_W-1 -: DATA_W];
  assign lb2_top = lb2_q[LB_N*DATA_W-1 -: DATA_W];

  always_comb begin
    state_d     = state_q;
    vr_d        = vr_q;
    vc_d        = vc_q;
    w_d         = w_q;
    bias_d      = bias_q;
    lb1_d       = lb1_q;
    lb2_d       = lb2_q;
    win_d       = win_q;
    prod_d      = prod_q;
    res_d       = res_q;
    wvalid_d    = 1'b0;
    pvalid_d    = wvalid_q;
    res_valid_d = pvalid_q;
    done_d      = 1'b0;
    adv         = 1'b0;
    pix         = '0;
    acc         = '0;

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        if (pixel_valid) begin
          adv = 1'b1;
          pix = pixel_in;
          if (vc_q == CW'(IMG_WIDTH - 1)) state_d = S_PAD;
        end
      end
      S_PAD: begin
        adv     = 1'b1;
        state_d = (vr_q == RW'(IMG_HEIGHT - 1)) ? S_FLUSH : S_RUN;
      end
      S_FLUSH: begin
        adv = 1'b1;
        if (vc_q == CW'(IMG_WIDTH)) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_valid_q && !pvalid_q && !wvalid_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      lb1_d = {lb1_q[(LB_N-1)*DATA_W-1:0], pix};
      lb2_d = {lb2_q[(LB_N-1)*DATA_W-1:0], lb1_top};
      // Column 0 starts a fresh window: older columns lie left of the frame.
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = (vc_q == '0) ? '0 : win_q[3*r+1];
        win_d[3*r+1] = (vc_q == '0) ? '0 : win_q[3*r+2];
      end
      win_d[2] = (vr_q >= RW'(2)) ? lb2_top : '0;
      win_d[5] = (vr_q >= RW'(1)) ? lb1_top : '0;
      win_d[8] = pix;
      wvalid_d = (vr_q != '0) && (vc_q != '0);
      if (vc_q == CW'(IMG_WIDTH)) begin
        vc_d = '0;
        vr_d = vr_q + RW'(1);
      end else begin
        vc_d = vc_q + CW'(1);
      end
    end

    if (wvalid_q) begin
      for (int k = 0; k < 9; k++) begin
        prod_d[k] = sx(win_q[k]) * sx(w_q[k*DATA_W +: DATA_W]);
      end
    end

    acc = {{(SW-16){bias_q[15]}}, bias_q};
    for (int k = 0; k < 9; k++) begin
      acc = acc + {{(SW-PW){prod_q[k][PW-1]}}, prod_q[k]};
    end
    if (pvalid_q) res_d = {{(OUT_W-SW){acc[SW-1]}}, acc};

    // A start anywhere aborts the frame and drops everything in flight.
    if (start_signal) begin
      state_d     = S_RUN;
      vr_d        = '0;
      vc_d        = '0;
      w_d         = weight_in;
      bias_d      = bias_in;
      wvalid_d    = 1'b0;
      pvalid_d    = 1'b0;
      res_valid_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      vr_q        <= '0;
      vc_q        <= '0;
      w_q         <= '0;
      bias_q      <= '0;
      lb1_q       <= '0;
      lb2_q       <= '0;
      wvalid_q    <= 1'b0;
      pvalid_q    <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      vr_q        <= vr_d;
      vc_q        <= vc_d;
      w_q         <= w_d;
      bias_q      <= bias_d;
      lb1_q       <= lb1_d;
      lb2_q       <= lb2_d;
      wvalid_q    <= wvalid_d;
      pvalid_q    <= pvalid_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      for (int k = 0; k < 9; k++) begin
        win_q[k]  <= win_d[k];
        prod_q[k] <= prod_d[k];
      end
    end
  end

  assign in_ready     = (state_q == S_RUN);
  assign result_out   = res_q;
  assign result_valid = res_valid_q;
  assign done_signal  = done_q;

endmodule
